// File: rtl/gemm_tile_scheduler_if.sv
// Handshake bundle between the GEMM tile scheduler, the PS start/done controller and the datapath.
// master = scheduler side, slave = controller/datapath side.
interface gemm_tile_scheduler_if #(
    parameter int unsigned M_LARGE  = 1024,
    parameter int unsigned N_LARGE  = 1024,
    parameter int unsigned M        = 32,
    parameter int unsigned N        = 32,
    parameter int unsigned K_PASSES = 32
);
    localparam int unsigned ROW_TILES = M_LARGE / M;
    localparam int unsigned COL_TILES = N_LARGE / N;
    localparam int unsigned ROW_W     = $clog2(ROW_TILES);
    localparam int unsigned COL_W     = $clog2(COL_TILES);
    localparam int unsigned K_W       = $clog2(K_PASSES);
    localparam int unsigned TILE_W    = ROW_W + COL_W;

    logic              start;
    logic              tile_start;
    logic [ROW_W-1:0]  tile_row_idx;
    logic [COL_W-1:0]  tile_col_idx;
    logic [K_W-1:0]    k_idx;
    logic              acc_clear;
    logic              tile_done;
    logic              op_wr_start;
    logic [TILE_W-1:0] op_wr_tile_idx;
    logic              op_wr_done;
    logic              busy;
    logic              done;
    logic [31:0]       active_clk_count;
    logic [4:0]        num_mat_done;

    modport master (
        input  start,
        input  tile_done,
        input  op_wr_done,
        output tile_start,
        output tile_row_idx,
        output tile_col_idx,
        output k_idx,
        output acc_clear,
        output op_wr_start,
        output op_wr_tile_idx,
        output busy,
        output done,
        output active_clk_count,
        output num_mat_done
    );

    modport slave (
        output start,
        output tile_done,
        output op_wr_done,
        input  tile_start,
        input  tile_row_idx,
        input  tile_col_idx,
        input  k_idx,
        input  acc_clear,
        input  op_wr_start,
        input  op_wr_tile_idx,
        input  busy,
        input  done,
        input  active_clk_count,
        input  num_mat_done
    );
endinterface

// File: rtl/gemm_tile_scheduler.sv
// Walks the M_LARGE x N_LARGE output in M x N tiles (column fastest), issuing K_PASSES
// accumulate passes per tile, then an output-URAM write, then a done pulse with statistics.
module gemm_tile_scheduler #(
    parameter int unsigned M_LARGE  = 1024,
    parameter int unsigned N_LARGE  = 1024,
    parameter int unsigned M        = 32,
    parameter int unsigned N        = 32,
    parameter int unsigned K_PASSES = 32
) (
    input logic                   clk,
    input logic                   reset,
    gemm_tile_scheduler_if.master bus
);
    localparam int unsigned ROW_TILES = M_LARGE / M;
    localparam int unsigned COL_TILES = N_LARGE / N;
    localparam int unsigned ROW_W     = $clog2(ROW_TILES);
    localparam int unsigned COL_W     = $clog2(COL_TILES);
    localparam int unsigned K_W       = $clog2(K_PASSES);
    localparam int unsigned TILE_W    = ROW_W + COL_W;

    localparam logic [ROW_W-1:0] RowLast = ROW_W'(ROW_TILES - 1);
    localparam logic [COL_W-1:0] ColLast = COL_W'(COL_TILES - 1);
    localparam logic [K_W-1:0]   KLast   = K_W'(K_PASSES - 1);

    if (ROW_TILES < 2 || (ROW_TILES & (ROW_TILES - 1)) != 0) begin : g_bad_row_tiles
        $error("ROW_TILES must be a power of two and at least 2");
    end
    if (COL_TILES < 2 || (COL_TILES & (COL_TILES - 1)) != 0) begin : g_bad_col_tiles
        $error("COL_TILES must be a power of two and at least 2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitPass,
        StWrite,
        StWaitWr,
        StFinish
    } state_e;

    state_e           state_q;
    logic             tile_start_q;
    logic             acc_clear_q;
    logic             op_wr_start_q;
    logic             busy_q;
    logic             done_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic [K_W-1:0]   k_q;
    logic [31:0]      active_q;
    logic [4:0]       num_mat_q;

    // Every output comes straight from a register; pulses are set on entry to their state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            tile_start_q  <= 1'b0;
            acc_clear_q   <= 1'b0;
            op_wr_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            k_q           <= '0;
            active_q      <= '0;
            num_mat_q     <= '0;
        end else begin
            tile_start_q  <= 1'b0;
            acc_clear_q   <= 1'b0;
            op_wr_start_q <= 1'b0;
            done_q        <= 1'b0;

            if (state_q != StIdle && active_q != 32'hFFFF_FFFF) begin
                active_q <= active_q + 32'd1;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        row_q        <= '0;
                        col_q        <= '0;
                        k_q          <= '0;
                        active_q     <= '0;
                        tile_start_q <= 1'b1;
                        acc_clear_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
                    state_q <= StWaitPass;
                end
                StWaitPass: begin
                    if (bus.tile_done) begin
                        if (k_q == KLast) begin
                            op_wr_start_q <= 1'b1;
                            state_q       <= StWrite;
                        end else begin
                            k_q          <= k_q + K_W'(1);
                            tile_start_q <= 1'b1;
                            state_q      <= StIssue;
                        end
                    end
                end
                StWrite: begin
                    state_q <= StWaitWr;
                end
                StWaitWr: begin
                    if (bus.op_wr_done) begin
                        if (row_q == RowLast && col_q == ColLast) begin
                            done_q    <= 1'b1;
                            num_mat_q <= num_mat_q + 5'd1;
                            state_q   <= StFinish;
                        end else begin
                            // COL_TILES is a power of two, so the column wraps on its own.
                            k_q          <= '0;
                            col_q        <= col_q + COL_W'(1);
                            if (col_q == ColLast) begin
                                row_q <= row_q + ROW_W'(1);
                            end
                            tile_start_q <= 1'b1;
                            acc_clear_q  <= 1'b1;
                            state_q      <= StIssue;
                        end
                    end
                end
                StFinish: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.tile_start       = tile_start_q;
    assign bus.acc_clear        = acc_clear_q;
    assign bus.tile_row_idx     = row_q;
    assign bus.tile_col_idx     = col_q;
    assign bus.k_idx            = k_q;
    assign bus.op_wr_start      = op_wr_start_q;
    // Power-of-two COL_TILES makes row*COL_TILES+col a plain concatenation.
    assign bus.op_wr_tile_idx   = TILE_W'({row_q, col_q});
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.active_clk_count = active_q;
    assign bus.num_mat_done     = num_mat_q;
endmodule
